// File: rtl/spi_slave_regs_if.sv
// spi_slave_regs_if: SPI pins plus fabric register side port of spi_slave_regs.
interface spi_slave_regs_if #(parameter int ADDR_W = 6);
  logic              spi_sclk;
  logic              spi_ss_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              reg_wr_en;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [7:0]        reg_wr_data;
  logic              spi_wr_strobe;
  logic [ADDR_W-1:0] spi_wr_addr;
  logic [7:0]        spi_wr_data;
  logic              busy;
  modport slave (
    input  spi_sclk, spi_ss_n, spi_mosi, reg_wr_en, reg_wr_addr, reg_wr_data,
    output spi_miso, spi_miso_oe, spi_wr_strobe, spi_wr_addr, spi_wr_data, busy
  );
  modport master (
    output spi_sclk, spi_ss_n, spi_mosi, reg_wr_en, reg_wr_addr, reg_wr_data,
    input  spi_miso, spi_miso_oe, spi_wr_strobe, spi_wr_addr, spi_wr_data, busy
  );
endinterface

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode 3 target exposing a 64x8 register bank, ADXL345-style framing.
module spi_slave_regs #(
  parameter logic [7:0] DEVID  = 8'hE5,
  parameter int         ADDR_W = 6
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  spi_slave_regs_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t            state_q, state_d;
  logic [2:0]        sclk_q, ss_q, cnt_q, cnt_d;
  logic [1:0]        mosi_q;
  logic [7:0]        rx_q, rx_d, tx_q, tx_d, wd_q, ld_data;
  logic [ADDR_W-1:0] addr_q, addr_d, wa_q, ld_addr;
  logic              miso_q, miso_d, rw_q, rw_d, mb_q, mb_d, first_q, first_d, stb_q, commit;
  logic              s_rise, s_fall, ss_rise, ss_fall;
  logic [7:0]        mem_q [2**ADDR_W];
  assign s_rise  = sclk_q[1] & ~sclk_q[2];
  assign s_fall  = ~sclk_q[1] & sclk_q[2];
  assign ss_rise = ss_q[1] & ~ss_q[2];
  assign ss_fall = ~ss_q[1] & ss_q[2];
  // In CMD the address comes straight from the byte being completed this cycle
  assign ld_addr = state_q == CMD ? {rx_q[ADDR_W-2:0], mosi_q[1]} : (mb_q ? addr_q + ADDR_W'(1) : addr_q);
  assign ld_data = ld_addr == '0 ? DEVID : mem_q[ld_addr];
  assign bus.spi_miso      = miso_q;
  assign bus.spi_miso_oe   = ~ss_q[1];
  assign bus.busy          = state_q != IDLE;
  assign bus.spi_wr_strobe = stb_q;
  assign bus.spi_wr_addr   = wa_q;
  assign bus.spi_wr_data   = wd_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    mb_d    = mb_q;
    first_d = first_q;
    commit  = 1'b0;
    if (ss_rise) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end else if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d = CMD;
        cnt_d   = '0;
        tx_d    = '0;
      end
    end else if (s_fall) begin
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end else if (s_rise) begin
      rx_d  = {rx_q[6:0], mosi_q[1]};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        state_d = DATA;
        addr_d  = ld_addr;
        rw_d    = state_q == CMD ? rx_d[7] : rw_q;
        mb_d    = state_q == CMD ? rx_d[6] : mb_q;
        first_d = state_q == CMD;
        commit  = state_q == DATA && !rw_q && (first_q || mb_q) && addr_q != '0;
        tx_d    = (state_q == CMD ? rx_d[7] : rw_q) ? ld_data : tx_q;
      end
    end
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_q  <= '1;
      ss_q    <= '1;
      mosi_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      mb_q    <= 1'b0;
      first_q <= 1'b0;
      stb_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], bus.spi_sclk};
      ss_q    <= {ss_q[1:0], bus.spi_ss_n};
      mosi_q  <= {mosi_q[0], bus.spi_mosi};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      mb_q    <= mb_d;
      first_q <= first_d;
      stb_q   <= commit;
      wa_q    <= commit ? addr_q : wa_q;
      wd_q    <= commit ? rx_d : wd_q;
    end
  end
  // SPI commit is written last so it overrides a same-address fabric write
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
    end else begin
      if (bus.reg_wr_en && bus.reg_wr_addr != '0) mem_q[bus.reg_wr_addr] <= bus.reg_wr_data;
      if (commit) mem_q[addr_q] <= rx_d;
    end
  end
endmodule
